// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: master requests and slave busy in,
// grants, ownership and timeout reporting out.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] m_req;
  logic                   slave_busy;
  logic [NUM_MASTERS-1:0] m_grant;
  logic [ID_WIDTH-1:0]    grant_id;
  logic                   bus_util;
  logic                   timeout_pulse;
  logic [ID_WIDTH-1:0]    timeout_id;

  // Arbiter side
  modport master (
    input  m_req, slave_busy,
    output m_grant, grant_id, bus_util, timeout_pulse, timeout_id
  );

  // Requester / monitor side
  modport slave (
    output m_req, slave_busy,
    input  m_grant, grant_id, bus_util, timeout_pulse, timeout_id
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter with turnaround cycle and hold watchdog.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_WIDTH       = $clog2(NUM_MASTERS)
) (
  input logic           clk,
  input logic           rstn,
  bus_arbiter_if.master bus
);
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWNED,
    S_TURNAROUND
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_mask;
  logic [ID_WIDTH-1:0]    r_grant_id;
  logic [ID_WIDTH-1:0]    r_timeout_id;
  logic                   r_bus_util;
  logic                   r_timeout_pulse;
  logic [CNT_W-1:0]       r_cnt;

  logic [NUM_MASTERS-1:0] w_eligible;
  logic                   w_found;
  logic [ID_WIDTH-1:0]    w_winner;
  logic                   w_owner_req;
  logic                   w_hold_expired;

  assign w_eligible     = bus.m_req & ~r_mask;
  assign w_owner_req    = bus.m_req[r_grant_id];
  assign w_hold_expired = !bus.slave_busy && (r_cnt == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_idx;

  // Scan downward from the far end so the last hit is the first index after r_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      w_idx = ID_WIDTH'((int'(r_ptr) + k) % NUM_MASTERS);
      if (w_eligible[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end
`else
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_mask          <= '0;
      r_grant_id      <= '0;
      r_timeout_id    <= '0;
      r_bus_util      <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_cnt           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_ptr           <= ID_WIDTH'(NUM_MASTERS - 1);
`endif
    end else begin
      r_timeout_pulse <= 1'b0;
      r_mask          <= r_mask & bus.m_req;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_OWNED;
            r_grant    <= NUM_MASTERS'(1) << w_winner;
            r_grant_id <= w_winner;
            r_bus_util <= 1'b1;
            r_cnt      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr      <= w_winner;
`endif
          end
        end
        S_OWNED: begin
          // A voluntary drop wins over a coincident timeout: no pulse, no mask.
          if (!w_owner_req) begin
            r_state    <= S_TURNAROUND;
            r_grant    <= '0;
            r_bus_util <= 1'b0;
          end else if (w_hold_expired) begin
            r_state         <= S_TURNAROUND;
            r_grant         <= '0;
            r_bus_util      <= 1'b0;
            r_timeout_pulse <= 1'b1;
            r_timeout_id    <= r_grant_id;
            r_mask          <= (r_mask & bus.m_req) | r_grant;
          end else if (!bus.slave_busy && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_TURNAROUND: r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_grant       = r_grant;
  assign bus.grant_id      = r_grant_id;
  assign bus.bus_util      = r_bus_util;
  assign bus.timeout_pulse = r_timeout_pulse;
  assign bus.timeout_id    = r_timeout_id;
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int IW = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(N), .ID_WIDTH(IW)) bus ();

  bus_arbiter #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(T),
    .ID_WIDTH      (IW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: who owns the bus (-1 none), whether a turnaround cycle is pending,
  // how many unbusy cycles the owner has held, and the timed-out set.
  int          m_owner;
  bit          m_gap;
  int          m_hold;
  bit [N-1:0]  m_mask;
  int          m_id;
  int          m_tid;
  bit          m_tp;
`ifdef ARB_ROUND_ROBIN_EN
  int          m_ptr;
`endif
  int          len [N];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int choose(input bit [N-1:0] e);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (e[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (e[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_hold = 0; m_mask = '0;
    m_id = 0; m_tid = 0; m_tp = 0;
`ifdef ARB_ROUND_ROBIN_EN
    m_ptr = N - 1;
`endif
  endtask

  task automatic model_step(input bit [N-1:0] req, input bit busy);
    bit [N-1:0] new_mask;
    int w;
    new_mask = m_mask & req;
    m_tp = 0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (!busy && m_hold == T - 1) begin
        m_tp = 1; m_tid = m_owner; new_mask[m_owner] = 1'b1;
        m_owner = -1; m_gap = 1;
      end else if (!busy) begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      w = choose(req & ~m_mask);
      if (w >= 0) begin
        m_owner = w; m_id = w; m_hold = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_ptr = w;
`endif
      end
    end
    m_mask = new_mask;
  endtask

  task automatic compare_all();
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("m_grant",       32'(bus.m_grant),       32'(eg));
    check("grant_id",      32'(bus.grant_id),      32'(m_id));
    check("bus_util",      32'(bus.bus_util),      32'(m_owner >= 0));
    check("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
    check("timeout_id",    32'(bus.timeout_id),    32'(m_tid));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step(bus.m_req, bus.slave_busy);
    #1;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int cnt;
    int gap;
    model_reset();
    bus.m_req      = '0;
    bus.slave_busy = 1'b0;
    for (int i = 0; i < N; i++) len[i] = 0;
    #1;
    compare_all();
    check("reset_util", 32'(bus.bus_util), 32'd0);
    cycles(2);
    rstn = 1'b1;
    cycles(2);

    // Single request
    bus.m_req = 4'b0100;
    cycle();
    check("single_grant", 32'(bus.m_grant),  32'h4);
    check("single_id",    32'(bus.grant_id), 32'd2);
    cycles(4);
    bus.m_req = 4'b0000;
    cycle();
    check("single_rel_util", 32'(bus.bus_util), 32'd0);
    check("single_rel_id",   32'(bus.grant_id), 32'd2);
    cycles(3);

    // Contention
    bus.m_req = 4'b1010;
    cycle();
`ifndef ARB_ROUND_ROBIN_EN
    check("cont_first", 32'(bus.grant_id), 32'd1);
`endif
    cycles(2);
    bus.m_req = bus.m_req & ~bus.m_grant;
    gap = 0;
    cycle();
    while (!bus.bus_util && gap < 10) begin gap++; cycle(); end
    check("cont_gap_min", 32'(gap >= 1), 32'd1);
    check("cont_second",  32'(bus.m_grant), 32'h8);
    bus.m_req = 4'b0000;
    cycles(3);

    // Hold watchdog
    bus.m_req = 4'b0001;
    cycle();
    cnt = 1;
    cycle();
    while (bus.bus_util && cnt < 20) begin cnt++; cycle(); end
    check("to_hold",  32'(cnt), 32'(T));
    check("to_pulse", 32'(bus.timeout_pulse), 32'd1);
    check("to_id",    32'(bus.timeout_id),    32'd0);
    cycle();
    check("to_pulse_once", 32'(bus.timeout_pulse), 32'd0);
    cycles(5);
    check("to_masked", 32'(bus.bus_util), 32'd0);
    bus.m_req = 4'b0000;
    cycle();
    bus.m_req = 4'b0001;
    cycle();
    check("to_regrant", 32'(bus.m_grant), 32'h1);
    bus.m_req = 4'b0000;
    cycles(3);

    // Busy freezes the watchdog
    bus.m_req = 4'b0010;
    cycle();
    cycles(3);
    bus.slave_busy = 1'b1;
    cycles(20);
    check("busy_held", 32'(bus.m_grant), 32'h2);
    bus.slave_busy = 1'b0;
    cnt = 0;
    cycle();
    while (bus.bus_util && cnt < 20) begin cnt++; cycle(); end
    check("busy_resume", 32'(cnt), 32'(T - 4));
    check("busy_to_id",  32'(bus.timeout_id), 32'd1);
    bus.m_req = 4'b0000;
    cycles(3);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.m_req[i]) begin
          if (m_owner == i) begin
            if (len[i] == 0) bus.m_req[i] = 1'b0;
            else len[i]--;
          end else if ($urandom % 16 == 0) begin
            bus.m_req[i] = 1'b0;
          end
        end else if ($urandom % 4 == 0) begin
          bus.m_req[i] = 1'b1;
          len[i] = $urandom_range(1, 12);
        end
      end
      bus.slave_busy = ($urandom % 4 == 0);
      cycle();
    end

    // Asynchronous reset while owned
    bus.m_req      = 4'b0000;
    bus.slave_busy = 1'b0;
    cycles(4);
    bus.m_req = 4'b0100;
    cycle();
    check("ar_owned", 32'(bus.bus_util), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_grant_drop", 32'(bus.m_grant),  32'd0);
    check("ar_util_drop",  32'(bus.bus_util), 32'd0);
    cycles(2);
    rstn = 1'b1;
    cycle();
    check("ar_regrant", 32'(bus.m_grant), 32'h4);
    check("ar_id",      32'(bus.grant_id), 32'd2);
    bus.m_req = 4'b0000;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
